dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 46 ++++
 rtl/dmem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle for the data-memory arbiter: pipeline (LSU) port, debug/loader port and memory side.
// The slave modport is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  p_req;
    logic                  p_we;
    logic [DM_ADDRESS-1:0] p_addr;
    logic [DATA_W-1:0]     p_wdata;
    logic [2:0]            p_funct3;
    logic                  p_ready;
    logic [DATA_W-1:0]     p_rdata;
    logic                  p_stall;
    logic                  p_misalign;

    logic                  d_req;
    logic                  d_we;
    logic [DM_ADDRESS-1:0] d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic                  d_ready;
    logic [DATA_W-1:0]     d_rdata;

    logic [DM_ADDRESS-1:0] m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [3:0]            m_wr;
    logic [DATA_W-1:0]     m_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata, p_funct3,
        output p_ready, p_rdata, p_stall, p_misalign,
        input  d_req, d_we, d_addr, d_wdata,
        output d_ready, d_rdata,
        output m_addr, m_wdata, m_wr,
        input  m_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata, p_funct3,
        input  p_ready, p_rdata, p_stall, p_misalign,
        output d_req, d_we, d_addr, d_wdata,
        input  d_ready, d_rdata,
        input  m_addr, m_wdata, m_wr,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: round-robin between the pipeline LSU and a debug/loader port,
// with RISC-V byte/halfword/word store lane steering and load alignment/extension.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input logic           clk,
    input logic           reset,
    dmem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OWN_P = 1'b0;
    localparam logic OWN_D = 1'b1;

    state_t                state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  owner_q, owner_d;
    logic                  we_q, we_d;
    logic [DM_ADDRESS-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic                  p_ready_q, p_ready_d;
    logic                  d_ready_q, d_ready_d;
    logic                  p_misalign_q, p_misalign_d;
    logic [DATA_W-1:0]     p_rdata_q, p_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;

    logic                  is_byte;
    logic                  is_half;
    logic                  misalign;
    logic [3:0]            lane_wr;
    logic [DATA_W-1:0]     lane_wdata;
    logic [DATA_W-1:0]     shifted;
    logic [DATA_W-1:0]     load_val;
    logic                  grant;

    // Store funct3 values outside SB/SH fall back to word; loads also decode LBU/LHU.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        if (we_q) begin
            is_byte = (funct3_q == 3'b000);
            is_half = (funct3_q == 3'b001);
        end else begin
            is_byte = (funct3_q[1:0] == 2'b00);
            is_half = (funct3_q[1:0] == 2'b01);
        end

        misalign = is_half ? addr_q[0] : (!is_byte && (addr_q[1:0] != 2'b00));

        if (is_byte) begin
            lane_wr    = 4'b0001 << addr_q[1:0];
            lane_wdata = {(DATA_W/8){wdata_q[7:0]}};
        end else if (is_half) begin
            lane_wr    = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {(DATA_W/16){wdata_q[15:0]}};
        end else begin
            lane_wr    = 4'b1111;
            lane_wdata = wdata_q;
        end
    end

    always_comb begin
        shifted = bus.m_rdata >> {addr_q[1:0], 3'b000};
        case (funct3_q)
            3'b000:  load_val = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_val = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            3'b001:  load_val = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            3'b101:  load_val = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
        if (misalign) begin
            load_val = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_q         <= OWN_P;
            owner_q      <= OWN_P;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            funct3_q     <= 3'b000;
            p_ready_q    <= 1'b0;
            d_ready_q    <= 1'b0;
            p_misalign_q <= 1'b0;
            p_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            funct3_q     <= funct3_d;
            p_ready_q    <= p_ready_d;
            d_ready_q    <= d_ready_d;
            p_misalign_q <= p_misalign_d;
            p_rdata_q    <= p_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Debug requests are latched as aligned word accesses so the shared datapath needs no special case.
    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        funct3_d     = funct3_q;
        p_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        p_misalign_d = 1'b0;
        p_rdata_d    = p_rdata_q;
        d_rdata_d    = d_rdata_q;
        grant        = OWN_P;

        case (state_q)
            IDLE: begin
                if (bus.p_req || bus.d_req) begin
                    if (bus.p_req && bus.d_req) begin
                        grant = rr_q;
                    end else begin
                        grant = bus.d_req ? OWN_D : OWN_P;
                    end
                    owner_d = grant;
                    rr_d    = ~grant;
                    state_d = ISSUE;
                    if (grant == OWN_P) begin
                        we_d     = bus.p_we;
                        addr_d   = bus.p_addr;
                        wdata_d  = bus.p_wdata;
                        funct3_d = bus.p_funct3;
                    end else begin
                        we_d     = bus.d_we;
                        addr_d   = bus.d_addr & {{(DM_ADDRESS-2){1'b1}}, 2'b00};
                        wdata_d  = bus.d_wdata;
                        funct3_d = 3'b010;
                    end
                end
            end
            ISSUE: begin
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
                if (owner_q == OWN_P) begin
                    p_ready_d    = 1'b1;
                    p_misalign_d = misalign;
                    if (!we_q) begin
                        p_rdata_d = load_val;
                    end
                end else begin
                    d_ready_d = 1'b1;
                    if (!we_q) begin
                        d_rdata_d = bus.m_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.m_addr     = {addr_q[DM_ADDRESS-1:2], 2'b00};
    assign bus.m_wdata    = lane_wdata;
    assign bus.m_wr       = (state_q == ISSUE && we_q && !misalign) ? lane_wr : 4'b0000;
    assign bus.p_ready    = p_ready_q;
    assign bus.p_rdata    = p_rdata_q;
    assign bus.p_misalign = p_misalign_q;
    assign bus.p_stall    = bus.p_req && !p_ready_q;
    assign bus.d_ready    = d_ready_q;
    assign bus.d_rdata    = d_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: byte-level reference memory, scoreboard of expected completions.
// A small behavioural RAM plays the memory side with one cycle of read latency.
module tb_dmem_arbiter;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        dbg;
        logic [31:0] rdata;
        logic        misalign;
    } exp_t;

    exp_t        sb[$];
    int          vectors;
    int          miscompares;
    logic [31:0] last_p_rdata;
    logic [31:0] last_d_rdata;

    logic [7:0]  mem     [0:511];
    logic [7:0]  ref_mem [0:511];
    logic        pre_we;
    logic [8:0]  pre_addr;
    logic [31:0] pre_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory side: byte-enabled writes, registered read one cycle after the address.
    always @(posedge clk) begin
        if (pre_we) begin
            for (int b = 0; b < 4; b++) mem[{pre_addr[8:2], 2'(b)}] <= pre_data[8*b +: 8];
        end
        for (int b = 0; b < 4; b++) begin
            if (bus.m_wr[b]) mem[{bus.m_addr[8:2], 2'(b)}] <= bus.m_wdata[8*b +: 8];
        end
        bus.m_rdata <= {mem[{bus.m_addr[8:2], 2'd3}], mem[{bus.m_addr[8:2], 2'd2}],
                        mem[{bus.m_addr[8:2], 2'd1}], mem[{bus.m_addr[8:2], 2'd0}]};
    end

    function automatic logic [31:0] memWord(input logic [8:0] a);
        return {mem[{a[8:2], 2'd3}], mem[{a[8:2], 2'd2}], mem[{a[8:2], 2'd1}], mem[{a[8:2], 2'd0}]};
    endfunction

    function automatic logic [31:0] refWord(input logic [8:0] a);
        return {ref_mem[{a[8:2], 2'd3}], ref_mem[{a[8:2], 2'd2}], ref_mem[{a[8:2], 2'd1}], ref_mem[{a[8:2], 2'd0}]};
    endfunction

    function automatic logic refMis(input logic [8:0] a, input logic [2:0] f, input logic we);
        if (we) begin
            if (f == 3'b000) return 1'b0;
            if (f == 3'b001) return a[0];
            return a[1:0] != 2'b00;
        end
        if (f == 3'b000 || f == 3'b100) return 1'b0;
        if (f == 3'b001 || f == 3'b101) return a[0];
        return a[1:0] != 2'b00;
    endfunction

    function automatic logic [31:0] refLoad(input logic [8:0] a, input logic [2:0] f);
        logic [7:0] b0, b1, b2, b3;
        if (refMis(a, f, 1'b0)) return 32'h0;
        b0 = ref_mem[a];
        b1 = ref_mem[a + 9'd1];
        b2 = ref_mem[a + 9'd2];
        b3 = ref_mem[a + 9'd3];
        case (f)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic refStore(input logic [8:0] a, input logic [2:0] f, input logic [31:0] w);
        if (f == 3'b000) begin
            ref_mem[a] = w[7:0];
        end else if (f == 3'b001) begin
            ref_mem[a]         = w[7:0];
            ref_mem[a + 9'd1]  = w[15:8];
        end else begin
            for (int b = 0; b < 4; b++) ref_mem[a + 9'(b)] = w[8*b +: 8];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [8:0] a, input logic [31:0] w);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = w;
        for (int b = 0; b < 4; b++) ref_mem[{a[8:2], 2'(b)}] = w[8*b +: 8];
        @(posedge clk);
        #1;
        pre_we = 1'b0;
    endtask

    task automatic applyStimulus(input logic dbg, input logic we, input logic [8:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3);
        if (dbg) begin
            bus.d_we    = we;
            bus.d_addr  = addr;
            bus.d_wdata = wdata;
            bus.d_req   = 1'b1;
        end else begin
            bus.p_we     = we;
            bus.p_addr   = addr;
            bus.p_wdata  = wdata;
            bus.p_funct3 = f3;
            bus.p_req    = 1'b1;
        end
    endtask

    // One complete access on either port: push expectation, drive, wait for ready, pop and compare.
    task automatic access(input string tag, input logic dbg, input logic we, input logic [8:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3,
                          input logic [3:0] exp_wr, input logic [31:0] exp_mwdata);
        exp_t        e;
        int          lat;
        logic [3:0]  seen_wr;
        logic [31:0] seen_wdata;
        logic        stall_ok;
        logic        rdy;
        e.dbg = dbg;
        if (dbg) begin
            e.misalign = 1'b0;
            e.rdata    = we ? last_d_rdata : refWord(addr);
            if (we) refStore({addr[8:2], 2'b00}, 3'b010, wdata);
            else last_d_rdata = e.rdata;
        end else begin
            e.misalign = refMis(addr, f3, we);
            e.rdata    = we ? last_p_rdata : refLoad(addr, f3);
            if (we && !e.misalign) refStore(addr, f3, wdata);
            if (!we) last_p_rdata = e.rdata;
        end
        sb.push_back(e);
        applyStimulus(dbg, we, addr, wdata, f3);
        lat        = -1;
        stall_ok   = 1'b1;
        seen_wr    = 4'h0;
        seen_wdata = 32'h0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                seen_wr    = bus.m_wr;
                seen_wdata = bus.m_wdata;
            end
            rdy = dbg ? bus.d_ready : bus.p_ready;
            if (rdy) begin
                if (!dbg && bus.p_stall !== 1'b0) stall_ok = 1'b0;
                lat = i;
                break;
            end
            if (!dbg && bus.p_stall !== 1'b1) stall_ok = 1'b0;
        end
        bus.p_req = 1'b0;
        bus.d_req = 1'b0;
        e = sb.pop_front();
        checkOutput({tag, ".latency"}, lat, 32'd3);
        checkOutput({tag, ".m_wr"}, {28'h0, seen_wr}, {28'h0, exp_wr});
        if (exp_wr != 4'h0) checkOutput({tag, ".m_wdata"}, seen_wdata, exp_mwdata);
        if (dbg) begin
            checkOutput({tag, ".d_rdata"}, bus.d_rdata, e.rdata);
        end else begin
            checkOutput({tag, ".p_stall"}, {31'h0, stall_ok}, 32'd1);
            checkOutput({tag, ".p_rdata"}, bus.p_rdata, e.rdata);
            checkOutput({tag, ".p_misalign"}, {31'h0, bus.p_misalign}, {31'h0, e.misalign});
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".p_ready"}, {31'h0, bus.p_ready}, 32'h0);
        checkOutput({tag, ".d_ready"}, {31'h0, bus.d_ready}, 32'h0);
        checkOutput({tag, ".p_misalign"}, {31'h0, bus.p_misalign}, 32'h0);
        checkOutput({tag, ".m_wr"}, {28'h0, bus.m_wr}, 32'h0);
        checkOutput({tag, ".p_rdata"}, bus.p_rdata, 32'h0);
        checkOutput({tag, ".d_rdata"}, bus.d_rdata, 32'h0);
        checkOutput({tag, ".m_addr"}, {23'h0, bus.m_addr}, 32'h0);
        checkOutput({tag, ".m_wdata"}, bus.m_wdata, 32'h0);
    endtask

    // Abort a word store while it is in ISSUE; memory must keep its old contents and no ready may follow.
    task automatic resetAbort();
        logic seen_ready;
        applyStimulus(1'b0, 1'b1, 9'h040, 32'h55AA55AA, 3'b010);
        @(posedge clk);
        #1;
        checkOutput("abort.issue_wr", {28'h0, bus.m_wr}, 32'hF);
        reset = 1'b1;
        #1;
        checkOutput("abort.wr_cleared", {28'h0, bus.m_wr}, 32'h0);
        bus.p_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues("abort");
        reset        = 1'b0;
        last_p_rdata = 32'h0;
        last_d_rdata = 32'h0;
        seen_ready   = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.p_ready || bus.d_ready) seen_ready = 1'b1;
        end
        checkOutput("abort.no_ready", {31'h0, seen_ready}, 32'h0);
        checkOutput("abort.mem040", memWord(9'h040), 32'h11111111);
    endtask

    // Both ports request continuously from a fresh reset; completions must alternate P,D,P,D.
    task automatic roundRobin();
        exp_t e;
        int   done;
        for (int k = 0; k < 4; k++) begin
            e.dbg      = (k % 2) == 1;
            e.rdata    = e.dbg ? refWord(9'h020) : refWord(9'h010);
            e.misalign = 1'b0;
            sb.push_back(e);
        end
        applyStimulus(1'b0, 1'b0, 9'h010, 32'h0, 3'b010);
        applyStimulus(1'b1, 1'b0, 9'h020, 32'h0, 3'b010);
        done = 0;
        for (int c = 0; c < 40 && done < 4; c++) begin
            @(posedge clk);
            #1;
            if (bus.p_ready || bus.d_ready) begin
                e = sb.pop_front();
                done++;
                checkOutput("rr.owner", {31'h0, bus.d_ready}, {31'h0, e.dbg});
                checkOutput("rr.single_ready", {31'h0, bus.p_ready & bus.d_ready}, 32'h0);
                checkOutput("rr.rdata", e.dbg ? bus.d_rdata : bus.p_rdata, e.rdata);
            end
        end
        bus.p_req = 1'b0;
        bus.d_req = 1'b0;
        checkOutput("rr.completions", done, 32'd4);
        sb.delete();
        last_p_rdata = refWord(9'h010);
        last_d_rdata = refWord(9'h020);
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        last_p_rdata = 32'h0;
        last_d_rdata = 32'h0;
        pre_we       = 1'b0;
        pre_addr     = 9'h0;
        pre_data     = 32'h0;
        for (int i = 0; i < 512; i++) ref_mem[i] = 8'h00;
        bus.p_req    = 1'b0;
        bus.p_we     = 1'b0;
        bus.p_addr   = 9'h0;
        bus.p_wdata  = 32'h0;
        bus.p_funct3 = 3'b000;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = 9'h0;
        bus.d_wdata  = 32'h0;
        reset        = 1'b1;
        for (int i = 0; i < 512; i += 4) preload(9'(i), 32'h0);
        #1;
        checkResetValues("reset");
        reset = 1'b0;
        preload(9'h010, 32'hDEADBEEF);
        preload(9'h020, 32'hCAFEF00D);
        preload(9'h040, 32'h11111111);
        preload(9'h060, 32'h80FF7F01);
        $display("[TB] pipeline accesses");
        access("lw010",  1'b0, 1'b0, 9'h010, 32'h0,      3'b010, 4'b0000, 32'h0);
        access("sb013",  1'b0, 1'b1, 9'h013, 32'h000000A5, 3'b000, 4'b1000, 32'hA5A5A5A5);
        access("lb013",  1'b0, 1'b0, 9'h013, 32'h0,      3'b000, 4'b0000, 32'h0);
        access("lbu013", 1'b0, 1'b0, 9'h013, 32'h0,      3'b100, 4'b0000, 32'h0);
        access("lh012",  1'b0, 1'b0, 9'h012, 32'h0,      3'b001, 4'b0000, 32'h0);
        access("lhu012", 1'b0, 1'b0, 9'h012, 32'h0,      3'b101, 4'b0000, 32'h0);
        access("sh021",  1'b0, 1'b1, 9'h021, 32'h0000BEEF, 3'b001, 4'b0000, 32'h0);
        access("lw020a", 1'b0, 1'b0, 9'h020, 32'h0,      3'b010, 4'b0000, 32'h0);
        access("sh022",  1'b0, 1'b1, 9'h022, 32'h00001234, 3'b001, 4'b1100, 32'h12341234);
        access("lw020b", 1'b0, 1'b0, 9'h020, 32'h0,      3'b010, 4'b0000, 32'h0);
        access("lw061",  1'b0, 1'b0, 9'h061, 32'h0,      3'b010, 4'b0000, 32'h0);
        access("lb061",  1'b0, 1'b0, 9'h061, 32'h0,      3'b000, 4'b0000, 32'h0);
        access("lb062",  1'b0, 1'b0, 9'h062, 32'h0,      3'b000, 4'b0000, 32'h0);
        access("lh062",  1'b0, 1'b0, 9'h062, 32'h0,      3'b001, 4'b0000, 32'h0);
        access("lh061",  1'b0, 1'b0, 9'h061, 32'h0,      3'b001, 4'b0000, 32'h0);
        access("sw_f7",  1'b0, 1'b1, 9'h044, 32'h0BADCAFE, 3'b111, 4'b1111, 32'h0BADCAFE);
        access("lw044",  1'b0, 1'b0, 9'h044, 32'h0,      3'b010, 4'b0000, 32'h0);
        $display("[TB] debug accesses");
        access("dwr0a3", 1'b1, 1'b1, 9'h0A3, 32'h13579BDF, 3'b000, 4'b1111, 32'h13579BDF);
        access("drd0a1", 1'b1, 1'b0, 9'h0A1, 32'h0,      3'b000, 4'b0000, 32'h0);
        access("plw0a0", 1'b0, 1'b0, 9'h0A0, 32'h0,      3'b010, 4'b0000, 32'h0);
        $display("[TB] reset during ISSUE");
        resetAbort();
        $display("[TB] round robin");
        roundRobin();
        access("lw040",  1'b0, 1'b0, 9'h040, 32'h0,      3'b010, 4'b0000, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
